// File: rtl/button_pkg.sv
// Shared state encoding and default 50 MHz timing for the push-button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_PEND = 2'd1,
        PRESSED    = 2'd2,
        REL_PEND   = 2'd3
    } key_state_t;

    localparam int DEF_N_BTN           = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;     // 1 ms
    localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms

endpackage

// File: rtl/key_debounce.sv
// One key channel: two-flop synchroniser, debounce FSM, registered level/pulses.
// The auto-repeat timer is built only when KEY_REPEAT_EN is defined.
//   state      | meaning
//   RELEASED   | accepted released, waiting for s=0
//   PRESS_PEND | s=0 seen, counting stable samples toward a press
//   PRESSED    | accepted pressed, waiting for s=1
//   REL_PEND   | s=1 seen, counting stable samples toward a release
module key_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             s;
    key_state_t       state_q;
    key_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_d;
    logic             press_d;
    logic             release_d;
    logic             press_edge;
    logic             rpt_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            s           <= 1'b1;
            state_q     <= RELEASED;
            cnt_q       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= key_raw;
            s           <= sync1;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
        end
    end

    // Any sample that disagrees with the pending change aborts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RELEASED: begin
                if (!s) begin
                    state_d = PRESS_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_PEND: begin
                if (s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (s) begin
                    state_d = REL_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            REL_PEND: begin
                if (!s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign press_edge = (state_q == PRESS_PEND) && (state_d == PRESSED);

    always_comb begin
        press_d   = press_edge || rpt_fire;
        release_d = (state_q == REL_PEND) && (state_d == RELEASED);
        level_d   = (state_d == PRESSED) || (state_d == REL_PEND);
    end

`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_q;
    logic             held;

    assign held = (state_q == PRESSED) || (state_q == REL_PEND);
    // A repeat landing on the release edge is dropped so the pulses never overlap.
    assign rpt_fire = held && (state_d != RELEASED) && (rpt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else if (press_edge) begin
            rpt_q <= RPT_FIRST;
        end else if (!held || (state_d == RELEASED)) begin
            rpt_q <= '0;
        end else if (rpt_q == '0) begin
            rpt_q <= RPT_NEXT;
        end else begin
            rpt_q <= rpt_q - RPT_W'(1);
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: N_BTN independent synchronise/debounce channels.
// Define KEY_REPEAT_EN to build the per-key auto-repeat of key_press.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             button0,
    input  logic [N_BTN-1:0] keys,
    output logic [N_BTN-1:0] key_level,
    output logic [N_BTN-1:0] key_press,
    output logic [N_BTN-1:0] key_release
);

    if ((N_BTN < 1) || (DEBOUNCE_CYCLES < 2) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_params
        $error("button_conditioner: illegal parameter set");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_key (
            .clk         (clk),
            .rst_n       (button0),
            .key_raw     (keys[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Timeline scoreboard bench for button_conditioner (DEBOUNCE 4, REPEAT 10/5).
module tb_button_conditioner;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
    } exp_t;

    logic       clk = 1'b0;
    logic       button0 = 1'b1;
    logic [1:0] keys = 2'b11;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;

    int         cyc = 0;
    int         base = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    exp_t       sb[$];
    logic [1:0] exp_level = 2'b00;
    logic [1:0] exp_p;
    logic [1:0] exp_r;

    button_conditioner #(
        .N_BTN           (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk         (clk),
        .button0     (button0),
        .keys        (keys),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_pulse(input int at, input logic [1:0] p, input logic [1:0] r);
        exp_t e;
        e.cyc   = at;
        e.press = p;
        e.rel   = r;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        #1 button0 = 1'b0;
        keys      = 2'b00;
        exp_level = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({key_level, key_press, key_release} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hold lvl/prs/rel got %b/%b/%b expected 00/00/00",
                         key_level, key_press, key_release);
            end
        end
        base    = cyc;
        button0 = 1'b1;
        keys    = 2'b10;
        expect_pulse(base + 6, 2'b01, 2'b00);
        expect_pulse(base + 12, 2'b00, 2'b01);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_p = sb[0].press; exp_r = sb[0].rel; sb.delete(0);
            end else begin
                exp_p = 2'b00; exp_r = 2'b00;
            end
            exp_level = (exp_level | exp_p) & ~exp_r;
            n_checks++;
            if ({key_level, key_press, key_release} !== {exp_level, exp_p, exp_r}) begin
                n_fail++;
                $display("FAIL reset_held_key edge %0d lvl/prs/rel got %b/%b/%b expected %b/%b/%b",
                         cyc - base, key_level, key_press, key_release, exp_level, exp_p, exp_r);
            end
            if (i == 6) keys[0] = 1'b1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_missing_pulses got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_clean_press();
        base    = cyc;
        keys[0] = 1'b0;
        expect_pulse(base + 6, 2'b01, 2'b00);
`ifdef KEY_REPEAT_EN
        expect_pulse(base + 16, 2'b01, 2'b00);
        expect_pulse(base + 21, 2'b01, 2'b00);
        expect_pulse(base + 26, 2'b01, 2'b00);
        expect_pulse(base + 31, 2'b01, 2'b00);
`endif
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_p = sb[0].press; exp_r = sb[0].rel; sb.delete(0);
            end else begin
                exp_p = 2'b00; exp_r = 2'b00;
            end
            exp_level = (exp_level | exp_p) & ~exp_r;
            n_checks++;
            if ({key_level, key_press, key_release} !== {exp_level, exp_p, exp_r}) begin
                n_fail++;
                $display("FAIL clean_press edge %0d lvl/prs/rel got %b/%b/%b expected %b/%b/%b",
                         cyc - base, key_level, key_press, key_release, exp_level, exp_p, exp_r);
            end
        end
    endtask

    // Continues the timeline of test_clean_press: release captured at edge 31.
    task automatic test_release();
        keys[0] = 1'b1;
        expect_pulse(base + 36, 2'b00, 2'b01);
        for (int i = 31; i <= 44; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_p = sb[0].press; exp_r = sb[0].rel; sb.delete(0);
            end else begin
                exp_p = 2'b00; exp_r = 2'b00;
            end
            exp_level = (exp_level | exp_p) & ~exp_r;
            n_checks++;
            if ({key_level, key_press, key_release} !== {exp_level, exp_p, exp_r}) begin
                n_fail++;
                $display("FAIL release edge %0d lvl/prs/rel got %b/%b/%b expected %b/%b/%b",
                         cyc - base, key_level, key_press, key_release, exp_level, exp_p, exp_r);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL press_release_missing_pulses got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_bounce();
        base    = cyc;
        keys[1] = 1'b0;
        expect_pulse(base + 10, 2'b10, 2'b00);
        expect_pulse(base + 16, 2'b00, 2'b10);
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_p = sb[0].press; exp_r = sb[0].rel; sb.delete(0);
            end else begin
                exp_p = 2'b00; exp_r = 2'b00;
            end
            exp_level = (exp_level | exp_p) & ~exp_r;
            n_checks++;
            if ({key_level, key_press, key_release} !== {exp_level, exp_p, exp_r}) begin
                n_fail++;
                $display("FAIL bounce edge %0d lvl/prs/rel got %b/%b/%b expected %b/%b/%b",
                         cyc - base, key_level, key_press, key_release, exp_level, exp_p, exp_r);
            end
            if (i == 3)  keys[1] = 1'b1;
            if (i == 4)  keys[1] = 1'b0;
            if (i == 10) keys[1] = 1'b1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_missing_pulses got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_concurrent();
        base = cyc;
        keys = 2'b00;
        expect_pulse(base + 6, 2'b11, 2'b00);
        expect_pulse(base + 12, 2'b00, 2'b11);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_p = sb[0].press; exp_r = sb[0].rel; sb.delete(0);
            end else begin
                exp_p = 2'b00; exp_r = 2'b00;
            end
            exp_level = (exp_level | exp_p) & ~exp_r;
            n_checks++;
            if ({key_level, key_press, key_release} !== {exp_level, exp_p, exp_r}) begin
                n_fail++;
                $display("FAIL concurrent edge %0d lvl/prs/rel got %b/%b/%b expected %b/%b/%b",
                         cyc - base, key_level, key_press, key_release, exp_level, exp_p, exp_r);
            end
            if (i == 6) keys = 2'b11;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL concurrent_missing_pulses got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Reset lands while key 1 is mid-debounce; the held key is re-debounced afterwards.
    task automatic test_reset_midcount();
        base = cyc;
        keys = 2'b01;
        expect_pulse(base + 11, 2'b10, 2'b00);
        expect_pulse(base + 17, 2'b00, 2'b10);
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_p = sb[0].press; exp_r = sb[0].rel; sb.delete(0);
            end else begin
                exp_p = 2'b00; exp_r = 2'b00;
            end
            exp_level = (exp_level | exp_p) & ~exp_r;
            n_checks++;
            if ({key_level, key_press, key_release} !== {exp_level, exp_p, exp_r}) begin
                n_fail++;
                $display("FAIL reset_midcount edge %0d lvl/prs/rel got %b/%b/%b expected %b/%b/%b",
                         cyc - base, key_level, key_press, key_release, exp_level, exp_p, exp_r);
            end
            if (i == 3) begin
                button0   = 1'b0;
                exp_level = 2'b00;
            end
            if (i == 5)  button0 = 1'b1;
            if (i == 11) keys[1] = 1'b1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_midcount_missing_pulses got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_concurrent();
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioner for the board push-buttons. It synchronises raw active-low key inputs, debounces them, and emits clean single-cycle press/release pulses and a stable level per key. It sits directly upstream of the switch-load/shift register stage, replacing that stage's ad-hoc two-flop edge detectors, whose push strobes it drives.

## Interface
- `N_BTN`, 2: number of conditioned keys; ≥1.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable samples required to accept a change; ≥2; 1 ms at 50 MHz.
- `REPEAT_DELAY`, 25000000: cycles from press pulse to first auto-repeat pulse; ≥1.
- `REPEAT_PERIOD`, 5000000: cycles between later auto-repeat pulses; ≥1.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `button0`  in  1  reset, asynchronous, active-low.
- `keys`  in  N_BTN  raw key inputs; active-low (0 = pressed); asynchronous to `clk`.
- `key_level`  out  N_BTN  debounced state; 1 = pressed.
- `key_press`  out  N_BTN  one-cycle pulse on accepted press, and on auto-repeat when enabled.
- `key_release`  out  N_BTN  one-cycle pulse on accepted release.

## Operation
- Each key is handled independently by an identical channel. There is no cross-key interaction.
- Synchroniser: two flops per key. Both reset to 1 (released). The channel uses only the second flop, `s`.
- Per-key FSM states: RELEASED, PRESS_PEND, PRESSED, REL_PEND. Counter `cnt` has width $clog2(DEBOUNCE_CYCLES).
  - RELEASED: if `s`=0, go to PRESS_PEND with `cnt`=1.
  - PRESS_PEND: if `s`=1, return to RELEASED with `cnt`=0 and no pulse. Else if `cnt`=DEBOUNCE_CYCLES−1, go to PRESSED, set `cnt`=0, pulse `key_press`. Else increment `cnt`.
  - PRESSED and REL_PEND mirror the above with polarity swapped. Entering RELEASED pulses `key_release`.
- `key_level` = 1 in PRESSED and REL_PEND. It is registered and changes on the same edge as the pulse.
- A bounce resets the counter, so any glitch shorter than DEBOUNCE_CYCLES produces no output.
- All outputs are registered. Pulses are exactly one cycle wide. `key_press` and `key_release` are never both high for the same key.
- Asynchronous reset:
  - Synchronisers go to 1, FSMs to RELEASED, all counters to 0.
  - `key_level`, `key_press` and `key_release` are all 0.
  - Reset mid-count discards the pending change. After reset deassertion, a key already held down is debounced from scratch.

## Timing
- If a new raw level is first captured by the synchroniser at edge n and then held, the state change and pulse occur at edge n+DEBOUNCE_CYCLES+1. The pulse is high for the following cycle only.
- Raw input must differ from the accepted state for DEBOUNCE_CYCLES consecutive `s` samples.
- Press and release latencies are identical.

## Configuration
- `KEY_REPEAT_EN` defined: auto-repeat is enabled.
  - While `key_level`=1, a per-key repeat counter runs from the press pulse.
  - Extra `key_press` pulses occur REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
  - The counter clears on release.
  - If a repeat coincides with the release edge, the release wins and no press pulse is emitted.
- `KEY_REPEAT_EN` undefined: exactly one `key_press` per accepted press. The repeat counters are not built, and the REPEAT_* parameters are ignored.

## Structure
- Package `button_pkg` holds:
  - `key_state_t` enum (RELEASED, PRESS_PEND, PRESSED, REL_PEND), 2-bit encoding.
  - The default-timing localparams for a 50 MHz board.
- Sub-module `key_debounce`: one channel containing the synchroniser, FSM, debounce counter and optional repeat counter. It is instantiated N_BTN times by generate.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- **Reset:** hold `button0`=0 with `keys`=0 → all outputs 0. Release reset with `keys[0]` still 0 → `key_press[0]` at edge 6 after deassertion (synchroniser refill plus 4-sample debounce).
- **Clean press:** `keys[0]` 1→0, first captured at edge 1 → `key_press[0]` high in the cycle after edge 6 only, `key_level[0]`=1 from edge 6. `key_release` stays 0.
- **Bounce:** `keys[1]` low for 3 samples, high 1, then low → no pulse from the first burst. Press is accepted at 5 edges past the last capture of 0.
- **Release:** after a press, `keys[0]` 0→1 captured at edge 31 → `key_release[0]` pulse after edge 36, `key_level[0]`=0.
- **Concurrent:** both keys pressed on the same edge → both `key_press` bits pulse in the same cycle.
- **Repeat, with `KEY_REPEAT_EN`:** press captured at edge 1, release captured at edge 31 → `key_press[0]` at edges 6, 16, 21, 26, 31. Edge 36 gives `key_release` only. Without the macro, `key_press[0]` pulses at edge 6 only.
